// File: rtl/tetris_pkg.sv
// tetris_pkg: shared board constants, row-clear FSM states and the score bonus table.
package tetris_pkg;

    localparam int BOARD_ROWS = 16;
    localparam int BOARD_COLS = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_EV,
        ST_FILL,
        ST_DONE
    } state_e;

    // Bonus indexed by rows cleared in one run; four or more rows earn the top entry.
    localparam logic [3:0] SCORE_BONUS [5] = '{4'd0, 4'd1, 4'd3, 4'd5, 4'd8};

    function automatic logic [3:0] score_bonus(input logic [7:0] cnt);
        return (cnt >= 8'd4) ? SCORE_BONUS[4] : SCORE_BONUS[{1'b0, cnt[1:0]}];
    endfunction

endpackage

// File: rtl/line_clear_score.sv
// line_clear_score: saturating 16-bit score accumulator, bumped once per completed clear run.
module line_clear_score
    import tetris_pkg::*;
#(
    parameter int CW = 5
) (
    input  logic          clka,
    input  logic          restart_n,
    input  logic          add_en_i,
    input  logic [CW-1:0] cnt_i,
    output logic [15:0]   score_o
);

    logic [15:0] score_q, score_d;
    logic [16:0] sum;

    always_comb begin
        sum     = {1'b0, score_q} + 17'(score_bonus(8'(cnt_i)));
        score_d = add_en_i ? (sum[16] ? 16'hFFFF : sum[15:0]) : score_q;
    end

    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) score_q <= '0;
        else            score_q <= score_d;
    end

    assign score_o = score_q;

endmodule

// File: rtl/line_clear.sv
// line_clear: bottom-up full-row removal and board compaction with top-row zero fill.
// Optional score accumulator enabled by defining LINE_CLEAR_SCORE_EN.
module line_clear
    import tetris_pkg::*;
#(
    parameter int ROWS = BOARD_ROWS,
    parameter int COLS = BOARD_COLS,
    parameter int RW   = $clog2(ROWS),
    parameter int CW   = $clog2(ROWS + 1)
) (
    input  logic            clka,
    input  logic            restart_n,
    input  logic            start_clear,
    output logic [RW-1:0]   row_rd_addr,
    input  logic [COLS-1:0] row_rd_data,
    output logic            row_wr_en,
    output logic [RW-1:0]   row_wr_addr,
    output logic [COLS-1:0] row_wr_data,
    output logic            busy,
    output logic            done,
    output logic            has_full,
    output logic [RW-1:0]   which_row,
    output logic [CW-1:0]   cleared_cnt
`ifdef LINE_CLEAR_SCORE_EN
    ,
    output logic [15:0]     score
`endif
);

    localparam logic [RW:0] LAST   = (RW+1)'(ROWS - 1);
    localparam logic [RW:0] ROWS_W = (RW+1)'(ROWS);

    state_e          state_q, state_d;
    logic [RW:0]     rd_q, rd_d, wr_q, wr_d, wr_nxt;
    logic            has_full_q, has_full_d;
    logic [RW-1:0]   which_q, which_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            row_full;

    assign row_full = &row_rd_data;
    assign wr_nxt   = wr_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        has_full_d  = has_full_q;
        which_d     = which_q;
        cnt_d       = cnt_q;
        row_wr_en   = 1'b0;
        row_wr_addr = '0;
        row_wr_data = '0;
        case (state_q)
            ST_IDLE: begin
                if (start_clear) begin
                    rd_d       = '0;
                    wr_d       = '0;
                    has_full_d = 1'b0;
                    which_d    = '0;
                    cnt_d      = '0;
                    state_d    = ST_RD;
                end
            end
            ST_RD: state_d = ST_EV;
            ST_EV: begin
                if (row_full) begin
                    cnt_d = cnt_q + 1'b1;
                    if (!has_full_q) begin
                        has_full_d = 1'b1;
                        which_d    = rd_q[RW-1:0];
                    end
                end else begin
                    // Rows below the first full row are already in place; skip rewriting them.
                    row_wr_en   = (wr_q != rd_q);
                    row_wr_addr = row_wr_en ? wr_q[RW-1:0] : '0;
                    row_wr_data = row_wr_en ? row_rd_data : '0;
                    wr_d        = wr_nxt;
                end
                rd_d    = rd_q + 1'b1;
                state_d = (rd_q != LAST) ? ST_RD : (wr_d < ROWS_W) ? ST_FILL : ST_DONE;
            end
            ST_FILL: begin
                row_wr_en   = 1'b1;
                row_wr_addr = wr_q[RW-1:0];
                wr_d        = wr_nxt;
                state_d     = (wr_q == LAST) ? ST_DONE : ST_FILL;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            state_q    <= ST_IDLE;
            rd_q       <= '0;
            wr_q       <= '0;
            has_full_q <= 1'b0;
            which_q    <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            has_full_q <= has_full_d;
            which_q    <= which_d;
            cnt_q      <= cnt_d;
        end
    end

    assign row_rd_addr = rd_q[RW-1:0];
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign has_full    = has_full_q;
    assign which_row   = which_q;
    assign cleared_cnt = cnt_q;

`ifdef LINE_CLEAR_SCORE_EN
    line_clear_score #(
        .CW(CW)
    ) u_score (
        .clka     (clka),
        .restart_n(restart_n),
        .add_en_i (state_q == ST_DONE),
        .cnt_i    (cnt_q),
        .score_o  (score)
    );
`endif

endmodule
